// File: rtl/chess_pkg.sv
// rtl/chess_pkg.sv - shared button indices, channel state encoding and default timing
package chess_pkg;

    localparam int BTN_IDX_L = 0;
    localparam int BTN_IDX_R = 1;
    localparam int BTN_IDX_U = 2;
    localparam int BTN_IDX_D = 3;
    localparam int BTN_IDX_C = 4;

    localparam int NUM_BTN_DEF       = 5;
    localparam int DEBOUNCE_CYC_DEF  = 488;
    localparam int REPEAT_DELAY_DEF  = 12207;
    localparam int REPEAT_PERIOD_DEF = 2441;
    localparam logic [4:0] REPEAT_MASK_DEF = 5'b01111;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_PRESS_WAIT   = 3'd1,
        ST_HELD_DELAY   = 3'd2,
        ST_HELD_REPEAT  = 3'd3,
        ST_RELEASE_WAIT = 3'd4
    } btn_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button: 2-flop synchroniser, debounce/auto-repeat FSM, registered outputs
module btn_channel
    import chess_pkg::*;
#(
    parameter int DEBOUNCE_CYC  = DEBOUNCE_CYC_DEF,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    input  logic i_repeat_en,
    output logic o_pulse,
    output logic o_level,
    output logic o_level_nxt
);

    localparam int CNT_W = $clog2(max3(DEBOUNCE_CYC, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    btn_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;
    logic             r_level;

    btn_state_e       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_pulse_nxt;
    logic             w_level_nxt;
    logic             w_s;

    assign w_s = r_sync2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pulse <= w_pulse_nxt;
            r_level <= w_level_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_ONE;
        case (r_state)
            ST_IDLE: begin
                if (w_s) begin
                    w_state_nxt = ST_PRESS_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!w_s) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_nxt = ST_HELD_DELAY;
                    w_cnt_nxt   = '0;
                end
            end
            ST_HELD_DELAY: begin
                if (!w_s) begin
                    w_state_nxt = ST_RELEASE_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end else if (!i_repeat_en) begin
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DLY_LAST) begin
                    w_state_nxt = ST_HELD_REPEAT;
                    w_cnt_nxt   = '0;
                end
            end
            ST_HELD_REPEAT: begin
                if (!w_s) begin
                    w_state_nxt = ST_RELEASE_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end else if (r_cnt == PER_LAST) begin
                    w_cnt_nxt   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                // A short low glitch while held re-enters the hold and restarts the repeat delay
                if (w_s) begin
                    w_state_nxt = ST_HELD_DELAY;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_pulse_nxt = 1'b0;
        w_level_nxt = 1'b0;
        if (w_s) begin
            w_pulse_nxt = ((r_state == ST_PRESS_WAIT)  && (r_cnt == DEB_LAST))
                       || ((r_state == ST_HELD_DELAY)  && i_repeat_en && (r_cnt == DLY_LAST))
                       || ((r_state == ST_HELD_REPEAT) && (r_cnt == PER_LAST));
        end
        w_level_nxt = (w_state_nxt == ST_HELD_DELAY) || (w_state_nxt == ST_HELD_REPEAT)
                   || (w_state_nxt == ST_RELEASE_WAIT);
    end

    assign o_pulse     = r_pulse;
    assign o_level     = r_level;
    assign o_level_nxt = w_level_nxt;

endmodule

// File: rtl/btn_pulse_gen.sv
// rtl/btn_pulse_gen.sv - multi-channel button conditioner producing move pulses and held levels
module btn_pulse_gen
    import chess_pkg::*;
#(
    parameter int NUM_BTN       = NUM_BTN_DEF,
    parameter int DEBOUNCE_CYC  = DEBOUNCE_CYC_DEF,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK = NUM_BTN'(REPEAT_MASK_DEF)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_BTN-1:0] BTN_RAW,
    output logic [NUM_BTN-1:0] BTN_PULSE,
    output logic [NUM_BTN-1:0] BTN_LEVEL,
    output logic               ANY_HELD
);

    logic [NUM_BTN-1:0] w_level_nxt;
    logic               r_any_held;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .i_clk      (CLK),
            .i_rst      (RESET),
            .i_raw      (BTN_RAW[gi]),
            .i_repeat_en(REPEAT_MASK[gi]),
            .o_pulse    (BTN_PULSE[gi]),
            .o_level    (BTN_LEVEL[gi]),
            .o_level_nxt(w_level_nxt[gi])
        );
    end

    // Registered from the channels' next levels so it lines up with BTN_LEVEL
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_any_held <= 1'b0;
        end else begin
            r_any_held <= |w_level_nxt;
        end
    end

    assign ANY_HELD = r_any_held;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// tb/tb_btn_pulse_gen.sv - self-checking bench for btn_pulse_gen
module tb_btn_pulse_gen;
    import chess_pkg::*;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;
    localparam logic [4:0] MASK = 5'b01111;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [4:0] BTN_RAW;
    logic [4:0] BTN_PULSE;
    logic [4:0] BTN_LEVEL;
    logic       ANY_HELD;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    btn_pulse_gen #(
        .NUM_BTN      (5),
        .DEBOUNCE_CYC (DEB),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP),
        .REPEAT_MASK  (MASK)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .BTN_RAW  (BTN_RAW),
        .BTN_PULSE(BTN_PULSE),
        .BTN_LEVEL(BTN_LEVEL),
        .ANY_HELD (ANY_HELD)
    );

    typedef struct {
        logic [4:0] raw;
        logic [4:0] pulse;
        logic [4:0] level;
        logic       any;
    } vec_t;

    vec_t tbl[70];

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [4:0] p, input logic [4:0] l, input logic a);
        check({tag, " pulse"}, BTN_PULSE, p);
        check({tag, " level"}, BTN_LEVEL, l);
        check({tag, " any"}, {4'b0, ANY_HELD}, {4'b0, a});
    endtask

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] r = '0;
        for (int k = lo; k <= hi; k++) r[k] = 1'b1;
        return r;
    endfunction

    // One channel driven from a raw pattern; row i's raw is sampled at edge i, outputs checked after it
    task automatic chk_seq(input string name, input int ch, input int n,
                           input logic [63:0] rawp, input logic [63:0] pulsep, input logic [63:0] levp);
        logic [4:0] oh;
        oh = 5'b00001 << ch;
        for (int i = 0; i < n; i++) begin
            BTN_RAW = rawp[i] ? oh : 5'b0;
            @(negedge CLK);
            check_outs($sformatf("%s row%0d", name, i),
                       pulsep[i] ? oh : 5'b0, levp[i] ? oh : 5'b0, levp[i]);
        end
    endtask

    // Reference model: run lengths of synchronised samples and hold age, no state machine
    int         m_s1[5], m_s2[5], m_lv[5], m_run[5], m_age[5];
    logic [4:0] exp_pulse, exp_level;

    task automatic model_reset();
        for (int c = 0; c < 5; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_lv[c] = 0; m_run[c] = 0; m_age[c] = 0;
        end
        exp_pulse = '0;
        exp_level = '0;
    endtask

    task automatic model_edge(input logic [4:0] raw);
        logic [4:0] mv;
        int s;
        mv = MASK;
        for (int c = 0; c < 5; c++) begin
            s = m_s2[c];
            m_s2[c] = m_s1[c];
            m_s1[c] = int'(raw[c]);
            exp_pulse[c] = 1'b0;
            if (m_lv[c] == 0) begin
                if (s != 0) begin
                    m_run[c]++;
                    if (m_run[c] == DEB) begin
                        m_lv[c] = 1; m_run[c] = 0; m_age[c] = 0; exp_pulse[c] = 1'b1;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end else if (s != 0) begin
                if (m_run[c] > 0) begin
                    m_run[c] = 0; m_age[c] = 0;
                end else begin
                    m_age[c]++;
                    if (mv[c] && m_age[c] >= RD && ((m_age[c] - RD) % RP) == 0)
                        exp_pulse[c] = 1'b1;
                end
            end else begin
                m_run[c]++;
                if (m_run[c] == DEB) begin
                    m_lv[c] = 0; m_run[c] = 0;
                end
            end
            exp_level[c] = (m_lv[c] != 0);
        end
    endtask

    initial begin
        int         rem[5];
        logic [4:0] cur;

        for (int i = 0; i < 70; i++) tbl[i] = '{raw: 5'b0, pulse: 5'b0, level: 5'b0, any: 1'b0};
        for (int i = 0; i < 40; i++) tbl[i].raw = 5'b10000;
        tbl[5].pulse = 5'b10000;
        for (int i = 5; i < 45; i++) begin tbl[i].level = 5'b10000; tbl[i].any = 1'b1; end
        for (int i = 50; i < 60; i++) tbl[i].raw = 5'b01001;
        tbl[55].pulse = 5'b01001;
        for (int i = 55; i < 65; i++) begin tbl[i].level = 5'b01001; tbl[i].any = 1'b1; end

        RESET   = 1'b1;
        BTN_RAW = 5'b0;
        #1;
        check_outs("reset", 5'b0, 5'b0, 1'b0);
        repeat (3) @(negedge CLK);
        RESET = 1'b0;

        for (int i = 0; i < 70; i++) begin
            BTN_RAW = tbl[i].raw;
            @(negedge CLK);
            check_outs($sformatf("table row%0d", i), tbl[i].pulse, tbl[i].level, tbl[i].any);
        end

        chk_seq("bounce", BTN_IDX_L, 30,
                rng(0, 2) | rng(4, 4) | rng(6, 17), rng(11, 11), rng(11, 22));
        chk_seq("repeat", BTN_IDX_U, 42, rng(0, 29),
                rng(5, 5) | rng(15, 15) | rng(18, 18) | rng(21, 21) | rng(24, 24) | rng(27, 27) | rng(30, 30),
                rng(5, 34));
        chk_seq("glitch", BTN_IDX_R, 48, rng(0, 18) | rng(21, 36),
                rng(5, 5) | rng(15, 15) | rng(18, 18) | rng(33, 33) | rng(36, 36), rng(5, 41));

        chk_seq("prehold", BTN_IDX_D, 12, rng(0, 11), rng(5, 5), rng(5, 11));
        #2;
        RESET = 1'b1;
        #1;
        check_outs("async reset", 5'b0, 5'b0, 1'b0);
        repeat (2) begin
            @(negedge CLK);
            check_outs("in reset", 5'b0, 5'b0, 1'b0);
        end
        RESET = 1'b0;
        chk_seq("posthold", BTN_IDX_D, 20, rng(0, 9), rng(5, 5), rng(5, 14));

        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        cur = 5'b0;
        for (int c = 0; c < 5; c++) rem[c] = 0;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            for (int c = 0; c < 5; c++) begin
                if (rem[c] == 0) begin
                    cur[c] = ~cur[c];
                    rem[c] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 3))
                                                         : int'($urandom_range(5, 40));
                end
                rem[c]--;
            end
            BTN_RAW = cur;
            @(negedge CLK);
            model_edge(cur);
            check_outs($sformatf("random cyc%0d", cyc), exp_pulse, exp_level, |exp_level);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
